// File: rtl/checkout_register.sv
// Point-of-sale checkout register: classifies scanned UPC codes, keeps a saturating
// price total and item count, and shows the total on active-low 7-segment digits.
module checkout_register #(
   parameter int DIGITS = 4,
   parameter int CNT_W  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [3:0]          upc,
   input  logic                scan,
   input  logic                clear,
   output logic [7*DIGITS-1:0] hex,
   output logic [CNT_W-1:0]    count,
   output logic                alarm,
   output logic                discount,
   output logic                err,
   output logic                busy
);

   localparam int MAX_TOTAL = 10**DIGITS - 1;
   localparam int TOTAL_W   = $clog2(10**DIGITS);
   localparam int BCD_W     = 4 * DIGITS;
   localparam int ITER_W    = $clog2(TOTAL_W + 1);
   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(TOTAL_W - 1);

   typedef enum logic [1:0] {IDLE, LOOKUP, ADD, CONV} state_t;

   function automatic int item_price(input logic [2:0] item);
      case (item)
         3'b000:  return 25;
         3'b001:  return 12;
         3'b011:  return 40;
         3'b100:  return 3;
         3'b101:  return 60;
         3'b110:  return 8;
         default: return 0;
      endcase
   endfunction

   function automatic logic is_invalid(input logic [3:0] code);
      return (code[2:0] == 3'b010) || (code[2:0] == 3'b111);
   endfunction

   function automatic logic is_stolen(input logic [3:0] code);
      return ~code[3] & ((code[0] & ~code[1]) | (~code[0] & ~code[2]));
   endfunction

   function automatic logic is_discounted(input logic [3:0] code);
      return code[1] | (code[0] & code[2]);
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] digit);
      case (digit)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Leading zero digits are blanked from the top down; digit 0 is always lit.
   function automatic logic [7*DIGITS-1:0] encode(input logic [BCD_W-1:0] bcd);
      logic [7*DIGITS-1:0] res;
      logic                lead;
      res  = '1;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (lead && (i != 0) && (bcd[4*i +: 4] == 4'd0)) begin
            res[7*i +: 7] = 7'b1111111;
         end else begin
            lead          = 1'b0;
            res[7*i +: 7] = seg7(bcd[4*i +: 4]);
         end
      end
      return res;
   endfunction

   // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
   function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] bcd, input logic in_bit);
      logic [BCD_W-1:0] adj;
      adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      return {adj[BCD_W-2:0], in_bit};
   endfunction

   localparam logic [7*DIGITS-1:0] HEX_ZERO = encode('0);

   state_t              state_q, state_d;
   logic [3:0]          upc_q, upc_d;
   logic [TOTAL_W-1:0]  total_q, total_d;
   logic [TOTAL_W-1:0]  bin_q, bin_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic [ITER_W-1:0]   iter_q, iter_d;
   logic [7*DIGITS-1:0] hex_q, hex_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                alarm_q, alarm_d;
   logic                discount_q, discount_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                scan_q, scan_d;
   logic [BCD_W-1:0]    bcd_step;
   int                  price;
   int                  sum;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
      state_d    = state_q;
      upc_d      = upc_q;
      total_d    = total_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      iter_d     = iter_q;
      hex_d      = hex_q;
      count_d    = count_q;
      alarm_d    = alarm_q;
      discount_d = discount_q;
      err_d      = 1'b0;
      busy_d     = busy_q;
      scan_d     = scan;
      price      = 0;
      sum        = 0;
      bcd_step   = dabble(bcd_q, bin_q[TOTAL_W-1]);

      if (clear) begin
         state_d    = IDLE;
         total_d    = '0;
         count_d    = '0;
         alarm_d    = 1'b0;
         discount_d = 1'b0;
         hex_d      = HEX_ZERO;
         busy_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (scan & ~scan_q) begin
                  upc_d   = upc;
                  state_d = LOOKUP;
                  busy_d  = 1'b1;
               end
            end
            LOOKUP: begin
               if (is_invalid(upc_q))     err_d      = 1'b1;
               else if (is_stolen(upc_q)) alarm_d    = 1'b1;
               else                       discount_d = is_discounted(upc_q);
               state_d = ADD;
            end
            ADD: begin
               if (!is_invalid(upc_q) && !is_stolen(upc_q)) begin
                  price   = is_discounted(upc_q) ? (item_price(upc_q[2:0]) >> 1)
                                                 : item_price(upc_q[2:0]);
                  sum     = int'(total_q) + price;
                  total_d = (sum > MAX_TOTAL) ? TOTAL_W'(MAX_TOTAL) : TOTAL_W'(sum);
                  count_d = (&count_q) ? count_q : count_q + CNT_W'(1);
               end
               bin_d   = total_d;
               bcd_d   = '0;
               iter_d  = '0;
               state_d = CONV;
            end
            CONV: begin
               bcd_d  = bcd_step;
               bin_d  = bin_q << 1;
               iter_d = iter_q + ITER_W'(1);
               if (iter_q == LAST_ITER) begin
                  hex_d   = encode(bcd_step);
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      if (reset) begin
         state_q    <= IDLE;
         upc_q      <= '0;
         total_q    <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         iter_q     <= '0;
         hex_q      <= HEX_ZERO;
         count_q    <= '0;
         alarm_q    <= 1'b0;
         discount_q <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         scan_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         upc_q      <= upc_d;
         total_q    <= total_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         iter_q     <= iter_d;
         hex_q      <= hex_d;
         count_q    <= count_d;
         alarm_q    <= alarm_d;
         discount_q <= discount_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         scan_q     <= scan_d;
      end
   end

   assign hex      = hex_q;
   assign count    = count_q;
   assign alarm    = alarm_q;
   assign discount = discount_q;
   assign err      = err_q;
   assign busy     = busy_q;

endmodule
